// File: rtl/gate_ex_pkg.sv
// ============================================================================
//  Module      : gate_ex_pkg
//  Description : Shared types, truth-table codes and helpers for gate_exerciser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_ex_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Vector index v = {a,b}
   typedef logic [1:0] vec_idx_t;

   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;

   function automatic logic [7:0] sat_inc(input logic [7:0] val);
      return (val == 8'hFF) ? val : val + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gate_ex_settle_timer.sv
// ============================================================================
//  Module      : gate_ex_settle_timer
//  Description : Loadable down-counter; expire is high while the count is 1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_ex_settle_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       expire
);

   logic [7:0] cnt_q;

   // Parks at zero once drained so a stale count never re-fires expire.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 8'd0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != 8'd0) begin
         cnt_q <= cnt_q - 8'd1;
      end
   end

   assign expire = (cnt_q == 8'd1);

endmodule

`default_nettype wire

// File: rtl/gate_exerciser.sv
// ============================================================================
//  Module      : gate_exerciser
//  Description : Drives a/b of a two-input gate through all vectors, checks f
//                against a truth table. Optional GATE_EXERCISER_FAILMASK_EN
//                adds the per-vector fail_mask output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_exerciser
   import gate_ex_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] truth_table,
   input  logic       gate_f,
   output logic       gate_a,
   output logic       gate_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
`ifdef GATE_EXERCISER_FAILMASK_EN
   output logic [3:0] fail_mask,
`endif
   output logic [1:0] first_fail
);

   localparam logic [7:0] C_SETTLE   = 8'(SETTLE_CYCLES);
   localparam logic [7:0] C_LAST_LOOP = 8'(LOOPS - 1);

   state_t     state_q, state_d;
   vec_idx_t   v_q, v_d;
   logic [7:0] loop_q, loop_d;
   logic [3:0] tt_q, tt_d;
   logic [7:0] err_q, err_d;
   vec_idx_t   ff_q, ff_d;
   logic       pass_q, pass_d;
   logic       done_q, done_d;
   logic       busy_q, busy_d;
   logic [3:0] mask_q, mask_d;

   logic w_load;
   logic w_expire;
   logic w_mismatch;

   gate_ex_settle_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val (C_SETTLE),
      .expire   (w_expire)
   );

   // Case inequality so an X/Z from a simulated gate is flagged, not masked.
   assign w_mismatch = (gate_f !== tt_q[v_q]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         v_q     <= '0;
         loop_q  <= '0;
         tt_q    <= '0;
         err_q   <= '0;
         ff_q    <= '0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         loop_q  <= loop_d;
         tt_q    <= tt_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      loop_d  = loop_q;
      tt_d    = tt_q;
      err_d   = err_q;
      ff_d    = ff_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      mask_d  = mask_q;
      w_load  = 1'b0;

      // busy covers the done cycle itself, then drops
      if (done_q) begin
         busy_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start && !busy_q) begin
               tt_d    = truth_table;
               err_d   = '0;
               ff_d    = '0;
               pass_d  = 1'b0;
               mask_d  = '0;
               v_d     = '0;
               loop_d  = '0;
               busy_d  = 1'b1;
               w_load  = 1'b1;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (w_expire) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (w_mismatch) begin
               err_d      = sat_inc(err_q);
               mask_d[v_q] = 1'b1;
               if (err_q == 8'd0) begin
                  ff_d = v_q;
               end
            end
            if (v_q == 2'd3 && loop_q == C_LAST_LOOP) begin
               state_d = S_DONE;
            end else begin
               if (v_q == 2'd3) begin
                  v_d    = '0;
                  loop_d = loop_q + 8'd1;
               end else begin
                  v_d = v_q + 2'd1;
               end
               w_load  = 1'b1;
               state_d = S_SETTLE;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            pass_d  = (err_q == 8'd0);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign gate_a     = v_q[1];
   assign gate_b     = v_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;

`ifdef GATE_EXERCISER_FAILMASK_EN
   assign fail_mask = mask_q;
`else
   logic w_unused_mask;
   assign w_unused_mask = ^mask_q;
`endif

endmodule

`default_nettype wire

// File: doc/gate_exerciser.md
# gate_exerciser

Self-checking stimulus driver for two-input primitive gates. Drives the gate's `a`/`b` inputs through all four input combinations and samples the gate's `f` output after a programmable settle time. Compares each sample against a 4-bit truth table and reports a pass/fail verdict with an error count. It sits on the opposite side of a gate's pins from the gate itself: it is the producer of `a`/`b` and the consumer of `f`. Switch-level gates (NOR, NAND, AND, ...) are wired to it for in-simulation and on-board characterisation.

## Interface
- `SETTLE_CYCLES`, default 2: cycles `gate_a`/`gate_b` are held before `gate_f` is sampled; legal range 1..255.
- `LOOPS`, default 1: full 4-vector passes per run; legal range 1..255.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: run request, sampled only in IDLE.
- `truth_table` input, 4 bits: expected `f` per vector, indexed by v = {a,b}; latched on start.
- `gate_f` input, 1 bit: gate output under test.
- `gate_a` output, 1 bit: gate input a, equal to v[1].
- `gate_b` output, 1 bit: gate input b, equal to v[0].
- `busy` output, 1 bit: run in progress.
- `done` output, 1 bit: one-cycle pulse at end of run.
- `pass` output, 1 bit: 1 if `err_count == 0` at end of run; held until the next start.
- `err_count` output, 8 bits: mismatch count, saturating at 255.
- `first_fail` output, 2 bits: vector index of the first mismatch; 0 if none.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On `start`, latch `truth_table`, clear `err_count`, `first_fail` and `pass`.
  - Set v=0 and loop=0, load the settle counter with SETTLE_CYCLES, then go to SETTLE.
- SETTLE: drive v on `gate_a`/`gate_b` and decrement the counter. When the counter reaches 1, go to SAMPLE.
- SAMPLE:
  - Compare `gate_f` with `tt_q[v]`. Any value other than a clean 0/1 match (X or Z in simulation) counts as a mismatch.
  - On a mismatch, increment `err_count` (saturating). On the first mismatch of the run, capture `first_fail` = v.
  - If v=3 and loop=LOOPS-1, go to DONE.
  - Otherwise, if v=3, set v=0 and loop++; else v++. Reload the counter and go to SETTLE.
- DONE: pulse `done`, set `pass`, return to IDLE.
- `start` while busy is ignored, with no restart and no queueing.
- `truth_table` changes after start have no effect on the current run.
- Reference truth-table codes: NOR 4'b0001, NAND 4'b0111, AND 4'b1000, OR 4'b1110, XOR 4'b0110.

## Timing
- Reset values: `gate_a`=0, `gate_b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail`=0, state IDLE.
- `busy` is 1 from the cycle after `start` until the cycle `done` is high, inclusive.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES cycles in SETTLE plus 1 cycle in SAMPLE.
- `gate_f` is sampled SETTLE_CYCLES+1 edges after the vector is first driven.
- `done` asserts LOOPS×4×(SETTLE_CYCLES+1)+1 cycles after the `start` edge.
- `pass` and `err_count` are valid in the `done` cycle and are held until the next accepted start.
- `gate_a`/`gate_b` change only on a SAMPLE→SETTLE transition or on start. They keep their last value in DONE and IDLE.
- Reset asserted mid-run: all outputs take their reset values at the next edge, and the run is abandoned without a `done` pulse.
- If `rst` and `start` are asserted in the same cycle, `rst` wins.

## Configuration
- `GATE_EXERCISER_FAILMASK_EN`:
  - Defined: adds the 4-bit output `fail_mask`. Bit v is set if vector v mismatched in any loop. It is cleared on start and on reset.
  - Undefined: the port is absent and there is no associated logic.

## Structure
- Package `gate_ex_pkg` holds:
  - the state enum;
  - the vector index type (2 bits);
  - the TT_NOR/TT_NAND/TT_AND/TT_OR/TT_XOR localparams;
  - the saturating-increment function.
- One sub-module, `gate_ex_settle_timer`: a loadable down-counter with `load`, `load_val` and `expire` ports.

## Test plan
- Ideal NOR model, truth_table=TT_NOR, SETTLE=2, LOOPS=1 → `done` 13 cycles after start, `pass`=1, `err_count`=0, `gate_a`/`gate_b` sequence 00,01,10,11.
- `gate_f` stuck at 1 with TT_NOR → `err_count`=3, `first_fail`=1, `pass`=0, `fail_mask`=4'b1110 (with the macro defined).
- Ideal NOR model checked against TT_NAND → `err_count`=2, `first_fail`=1, `fail_mask`=4'b0110.
- `gate_f` driven X on vector 3 only, TT_NOR → `err_count`=1, `first_fail`=3.
- LOOPS=100, `gate_f` stuck at 1 with TT_NOR → `err_count` saturates at 255.
- Reset 5 cycles into a run, plus a second `start` pulsed mid-run in a separate run → after reset, all outputs are at reset values with no `done`. The mid-run `start` is ignored, and the `done` timing is unchanged.
